seq_shifter: RTL and testbench



---
 rtl/seq_shifter.sv | 123 ++++++++++++
 tb/tb_seq_shifter.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/seq_shifter.sv
// seq_shifter: multi-cycle WIDTH-bit shifter/rotator.
// Shifts the captured operand by 2 per cycle, and by 1 for an odd
// remainder, then pulses done for one cycle.
//
// Ports:
//   clk    in   rising-edge clock
//   rst    in   synchronous, active-high reset
//   start  in   request, sampled only in IDLE
//   In     in   [WIDTH-1:0] operand
//   Op     in   [1:0] 00 ROL, 01 SLL, 10 SRA, 11 SRL
//   Cnt    in   [CNT_W-1:0] shift amount, 0..WIDTH-1
//   Out    out  [WIDTH-1:0] result register
//   busy   out  high whenever state is not IDLE
//   done   out  one-cycle pulse in the DONE state
module seq_shifter #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] In,
  input  logic [1:0]       Op,
  input  logic [CNT_W-1:0] Cnt,
  output logic [WIDTH-1:0] Out,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    OP_ROL = 2'b00,
    OP_SLL = 2'b01,
    OP_SRA = 2'b10,
    OP_SRL = 2'b11
  } op_e;

  state_e           r_state;
  op_e              r_op;
  logic [WIDTH-1:0] r_data;
  logic [CNT_W-1:0] r_rem;

  logic [WIDTH-1:0] w_sh1;
  logic [WIDTH-1:0] w_sh2;

  // Single- and double-bit shifts of the working register per captured op.
  always_comb begin
    w_sh1 = r_data;
    w_sh2 = r_data;
    unique case (r_op)
      OP_ROL: begin
        w_sh1 = {r_data[WIDTH-2:0], r_data[WIDTH-1]};
        w_sh2 = {r_data[WIDTH-3:0], r_data[WIDTH-1:WIDTH-2]};
      end
      OP_SLL: begin
        w_sh1 = {r_data[WIDTH-2:0], 1'b0};
        w_sh2 = {r_data[WIDTH-3:0], 2'b00};
      end
      OP_SRA: begin
        w_sh1 = {r_data[WIDTH-1], r_data[WIDTH-1:1]};
        w_sh2 = {{2{r_data[WIDTH-1]}}, r_data[WIDTH-1:2]};
      end
      OP_SRL: begin
        w_sh1 = {1'b0, r_data[WIDTH-1:1]};
        w_sh2 = {2'b00, r_data[WIDTH-1:2]};
      end
      default: begin
        w_sh1 = r_data;
        w_sh2 = r_data;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_op    <= OP_ROL;
      r_data  <= '0;
      r_rem   <= '0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (start) begin
            r_data  <= In;
            r_op    <= op_e'(Op);
            r_rem   <= Cnt;
            r_state <= SHIFT;
          end
        end
        SHIFT: begin
          if (r_rem >= CNT_W'(2)) begin
            r_data  <= w_sh2;
            r_rem   <= r_rem - CNT_W'(2);
            r_state <= (r_rem == CNT_W'(2)) ? DONE : SHIFT;
          end else if (r_rem == CNT_W'(1)) begin
            r_data  <= w_sh1;
            r_rem   <= '0;
            r_state <= DONE;
          end else begin
            // Zero shift amount still spends one SHIFT cycle.
            r_state <= DONE;
          end
        end
        DONE: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign Out  = r_data;
  assign busy = (r_state != IDLE);
  assign done = (r_state == DONE);

endmodule

// File: tb/tb_seq_shifter.sv
module tb_seq_shifter;

  logic        clk;
  logic        rst;
  logic        start;
  logic [15:0] In;
  logic [1:0]  Op;
  logic [3:0]  Cnt;
  logic [15:0] Out;
  logic        busy;
  logic        done;

  seq_shifter #(.WIDTH(16), .CNT_W(4)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .In    (In),
    .Op    (Op),
    .Cnt   (Cnt),
    .Out   (Out),
    .busy  (busy),
    .done  (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int n_done  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Whole-amount reference result of shifting x by a bits.
  function automatic logic [15:0] ref_shift(input logic [15:0] x, input logic [1:0] op,
                                            input int unsigned a);
    logic [15:0] r;
    case (op)
      2'b00:   r = (a == 0) ? x : ((x << a) | (x >> (16 - a)));
      2'b01:   r = x << a;
      2'b10:   r = 16'($signed(x) >>> a);
      default: r = x >> a;
    endcase
    return r;
  endfunction

  // Model: the operation advances 2 bits of shift amount per busy cycle,
  // and Out always equals the input shifted by the amount applied so far.
  logic        m_valid = 1'b0;
  logic        m_busy, m_done;
  logic [15:0] m_in, m_out;
  logic [1:0]  m_op;
  int unsigned m_cnt, m_applied;

  always @(posedge clk) begin
    if (rst) begin
      m_valid = 1'b1;
      m_busy  = 1'b0;
      m_done  = 1'b0;
      m_out   = 16'h0;
    end else if (m_done) begin
      m_done = 1'b0;
      m_busy = 1'b0;
    end else if (m_busy) begin
      m_applied = (m_applied + 2 > m_cnt) ? m_cnt : m_applied + 2;
      m_out     = ref_shift(m_in, m_op, m_applied);
      if (m_applied == m_cnt) m_done = 1'b1;
    end else if (start) begin
      m_busy    = 1'b1;
      m_in      = In;
      m_op      = Op;
      m_cnt     = Cnt;
      m_applied = 0;
      m_out     = In;
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      check("busy", 32'(busy), 32'(m_busy));
      check("done", 32'(done), 32'(m_done));
      check("Out",  32'(Out),  32'(m_out));
    end
    if (done) n_done++;
  end

  // Runs one operation; edge 1 is the capture edge. With spam set, start is
  // re-asserted with junk operands at edges 2..5, all of which must be ignored.
  task automatic run_op(input logic [15:0] a, input logic [1:0] op, input logic [3:0] c,
                        input logic [15:0] exp_out, input int exp_edges, input bit spam,
                        input string name);
    int edges;
    int d0;
    @(negedge clk);
    d0    = n_done;
    In    = a;
    Op    = op;
    Cnt   = c;
    start = 1'b1;
    @(posedge clk);
    edges = 1;
    @(negedge clk);
    start = spam;
    In    = 16'h1357;
    Op    = 2'b01;
    Cnt   = 4'd3;
    while (!done && edges < 40) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
      start = spam && (edges <= 4);
      In    = In + 16'h0101;
    end
    start = 1'b0;
    check({name, "_latency"}, 32'(edges), 32'(exp_edges));
    check({name, "_result"}, 32'(Out), 32'(exp_out));
    repeat (3) @(negedge clk);
    check({name, "_pulses"}, 32'(n_done - d0), 32'd1);
    check({name, "_hold"}, 32'(Out), 32'(exp_out));
  endtask

  initial begin
    int d0;
    rst = 1'b1; start = 1'b0; In = '0; Op = '0; Cnt = '0;
    repeat (2) @(negedge clk);
    check("reset_out", 32'(Out), 32'h0);
    check("reset_busy", 32'(busy), 32'h0);
    check("reset_done", 32'(done), 32'h0);
    rst = 1'b0;

    run_op(16'h1234, 2'b00, 4'd5,  16'h4682, 4, 1'b0, "rol5");
    run_op(16'h00FF, 2'b01, 4'd4,  16'h0FF0, 3, 1'b0, "sll4");
    run_op(16'h8000, 2'b11, 4'd15, 16'h0001, 9, 1'b0, "srl15");
    run_op(16'h8000, 2'b10, 4'd15, 16'hFFFF, 9, 1'b0, "sra15");
    run_op(16'h4000, 2'b10, 4'd2,  16'h1000, 2, 1'b0, "sra2");
    run_op(16'hBEEF, 2'b11, 4'd0,  16'hBEEF, 2, 1'b0, "cnt0");
    run_op(16'h8001, 2'b00, 4'd1,  16'h0003, 2, 1'b0, "rol1");
    run_op(16'hF000, 2'b11, 4'd3,  16'h1E00, 3, 1'b0, "srl3");
    run_op(16'hAAAA, 2'b00, 4'd8,  16'hAAAA, 5, 1'b1, "busy_start");

    // Reset in the middle of a long SLL aborts it without a done pulse.
    @(negedge clk);
    d0 = n_done;
    In = 16'h0001; Op = 2'b01; Cnt = 4'd14; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("abort_busy", 32'(busy), 32'h0);
    check("abort_out", 32'(Out), 32'h0);
    repeat (10) @(negedge clk);
    check("abort_no_done", 32'(n_done - d0), 32'h0);

    run_op(16'h0001, 2'b01, 4'd14, 16'h4000, 8, 1'b0, "sll14");

    // Reset and start together: reset wins.
    @(negedge clk);
    rst = 1'b1; start = 1'b1; In = 16'h5555; Cnt = 4'd2;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    check("rst_start_busy", 32'(busy), 32'h0);
    check("rst_start_out", 32'(Out), 32'h0);
    repeat (2) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
